// File: rtl/osd_trace_depacketization.sv
// osd_trace_depacketization
//
// Receive side of the trace packetization path. It consumes DII event packets
// from a 16-bit flit stream and rebuilds each fixed-width trace event word.
// Overflow-notification packets are folded into a pending flag and a lost-event
// count. Both are attached to the next event that is delivered.
//
// Packet layout: DEST, SRC, FLAGS, then the payload.
//   FLAGS[15:14] = TYPE (2'b10 for event packets)
//   FLAGS[13:10] = TYPE_SUB (4'h0 trace event, 4'h5 overflow notification)
//   Trace event payload: NUM_WORDS flits, least-significant word first.
//   Overflow payload   : one flit holding the number of lost events.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   id                own address; packets with a different DEST are dropped
//   debug_in          incoming flit (valid, last, data)
//   debug_in_ready    flit accepted when debug_in.valid & debug_in_ready
//   trace_data        reassembled event word
//   trace_src         SRC field of the packet that carried the event
//   trace_overflow    events were lost just before this one
//   trace_lost        number of lost events (meaningful with trace_overflow)
//   trace_valid       event available
//   trace_ready       consumer accepts the event
//   drop_count        saturating count of malformed or misaddressed packets

package osd_dii_pkg;
    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;
endpackage

module osd_trace_depacketization
    import osd_dii_pkg::*;
#(
    parameter int WIDTH = 112
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      id,
    input  dii_flit          debug_in,
    output logic             debug_in_ready,
    output logic [WIDTH-1:0] trace_data,
    output logic [15:0]      trace_src,
    output logic             trace_overflow,
    output logic [15:0]      trace_lost,
    output logic             trace_valid,
    input  logic             trace_ready,
    output logic [15:0]      drop_count
);

    localparam int NUM_WORDS = (WIDTH + 15) / 16;
    localparam int CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);

    localparam logic [1:0] TYPE_EVENT    = 2'b10;
    localparam logic [3:0] SUB_TRACE     = 4'h0;
    localparam logic [3:0] SUB_OVERFLOW  = 4'h5;

    typedef enum logic [2:0] {
        ST_DEST,
        ST_SRC,
        ST_FLAGS,
        ST_PAYLOAD,
        ST_OVFL,
        ST_DROP,
        ST_OUT
    } state_t;

    state_t state_q;
    state_t next_state;

    logic [15:0]              src_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [NUM_WORDS*16-1:0]  words_q;
    logic                     pending_ovf_q;
    logic [15:0]              pending_lost_q;
    logic [15:0]              drop_count_q;

    logic        accept;
    logic        src_load;
    logic        cnt_clear;
    logic        word_load;
    logic        ovf_load;
    logic        pending_clear;
    logic        drop_inc;
    logic [16:0] lost_sum;

    assign accept = debug_in.valid & debug_in_ready;

    // Lost-count accumulation is done one bit wider so that saturation can be
    // detected from the carry instead of wrapping.
    assign lost_sum = {1'b0, pending_lost_q} + {1'b0, debug_in.data};

    // State register of the packet parser.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_DEST;
        end else begin
            state_q <= next_state;
        end
    end

    // Next-state and control decode. Every state advances only on an accepted
    // flit, except OUT, which waits for the consumer. A last flit that arrives
    // before the header is complete counts as a truncated packet, and the
    // parser goes back to DEST. Each drop_count increment is raised exactly
    // once per bad packet. For packets that still have flits to discard, the
    // increment happens on the transition into DROP.
    always_comb begin
        next_state     = state_q;
        debug_in_ready = 1'b1;
        trace_valid    = 1'b0;
        src_load       = 1'b0;
        cnt_clear      = 1'b0;
        word_load      = 1'b0;
        ovf_load       = 1'b0;
        pending_clear  = 1'b0;
        drop_inc       = 1'b0;

        case (state_q)
            ST_DEST: begin
                if (accept) begin
                    if (debug_in.last) begin
                        drop_inc = 1'b1;
                    end else if (debug_in.data != id) begin
                        drop_inc   = 1'b1;
                        next_state = ST_DROP;
                    end else begin
                        next_state = ST_SRC;
                    end
                end
            end
            ST_SRC: begin
                if (accept) begin
                    if (debug_in.last) begin
                        drop_inc   = 1'b1;
                        next_state = ST_DEST;
                    end else begin
                        src_load   = 1'b1;
                        next_state = ST_FLAGS;
                    end
                end
            end
            ST_FLAGS: begin
                if (accept) begin
                    if (debug_in.last) begin
                        drop_inc   = 1'b1;
                        next_state = ST_DEST;
                    end else if (debug_in.data[15:14] == TYPE_EVENT &&
                                 debug_in.data[13:10] == SUB_TRACE) begin
                        cnt_clear  = 1'b1;
                        next_state = ST_PAYLOAD;
                    end else if (debug_in.data[15:14] == TYPE_EVENT &&
                                 debug_in.data[13:10] == SUB_OVERFLOW) begin
                        next_state = ST_OVFL;
                    end else begin
                        drop_inc   = 1'b1;
                        next_state = ST_DROP;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (accept) begin
                    word_load = 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        if (debug_in.last) begin
                            next_state = ST_OUT;
                        end else begin
                            drop_inc   = 1'b1;
                            next_state = ST_DROP;
                        end
                    end else if (debug_in.last) begin
                        drop_inc   = 1'b1;
                        next_state = ST_DEST;
                    end
                end
            end
            ST_OVFL: begin
                if (accept) begin
                    ovf_load = 1'b1;
                    if (debug_in.last) begin
                        next_state = ST_DEST;
                    end else begin
                        drop_inc   = 1'b1;
                        next_state = ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                if (accept && debug_in.last) begin
                    next_state = ST_DEST;
                end
            end
            ST_OUT: begin
                debug_in_ready = 1'b0;
                trace_valid    = 1'b1;
                if (trace_ready) begin
                    pending_clear = 1'b1;
                    next_state    = ST_DEST;
                end
            end
            default: begin
                next_state = ST_DEST;
            end
        endcase
    end

    // Datapath registers. No flit is accepted in OUT, so the payload words,
    // the source and the pending overflow state stay frozen while an event is
    // held. This keeps the outputs stable until the event is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_q          <= '0;
            cnt_q          <= '0;
            words_q        <= '0;
            pending_ovf_q  <= 1'b0;
            pending_lost_q <= '0;
            drop_count_q   <= '0;
        end else begin
            if (src_load) begin
                src_q <= debug_in.data;
            end

            if (cnt_clear) begin
                cnt_q <= '0;
            end else if (word_load) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            if (word_load) begin
                for (int i = 0; i < NUM_WORDS; i++) begin
                    if (cnt_q == CNT_W'(i)) begin
                        words_q[i*16 +: 16] <= debug_in.data;
                    end
                end
            end

            if (pending_clear) begin
                pending_ovf_q  <= 1'b0;
                pending_lost_q <= '0;
            end else if (ovf_load) begin
                pending_ovf_q  <= 1'b1;
                pending_lost_q <= lost_sum[16] ? 16'hFFFF : lost_sum[15:0];
            end

            if (drop_inc && drop_count_q != 16'hFFFF) begin
                drop_count_q <= drop_count_q + 16'd1;
            end
        end
    end

    // Bits of the last payload word above WIDTH are discarded here.
    assign trace_data     = words_q[WIDTH-1:0];
    assign trace_src      = src_q;
    assign trace_overflow = pending_ovf_q;
    assign trace_lost     = pending_lost_q;
    assign drop_count     = drop_count_q;

endmodule

// File: tb/tb_osd_trace_depacketization.sv
// tb_osd_trace_depacketization
//
// Self-checking bench for osd_trace_depacketization. The stimulus tasks push
// the expected event onto a scoreboard when they send a packet. A monitor pops
// and compares each event when the DUT hands it over. Inputs change on the
// falling edge, or just after a rising edge, so the DUT samples them cleanly.

module tb_osd_trace_depacketization;
    import osd_dii_pkg::*;

    localparam int WIDTH     = 112;
    localparam int NUM_WORDS = (WIDTH + 15) / 16;
    localparam logic [15:0] OWN_ID = 16'h0005;

    logic             clk = 1'b0;
    logic             rst;
    logic [15:0]      id;
    dii_flit          debug_in;
    logic             debug_in_ready;
    logic [WIDTH-1:0] trace_data;
    logic [15:0]      trace_src;
    logic             trace_overflow;
    logic [15:0]      trace_lost;
    logic             trace_valid;
    logic             trace_ready;
    logic [15:0]      drop_count;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [15:0]      src;
        logic             ovf;
        logic [15:0]      lost;
    } event_t;

    event_t      sb[$];
    logic [15:0] pktQ[$];
    int          checkCount = 0;
    int          passCount  = 0;

    logic        modelOvf;
    logic [15:0] modelLost;
    logic [15:0] modelDrop;

    osd_trace_depacketization #(.WIDTH(WIDTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .id             (id),
        .debug_in       (debug_in),
        .debug_in_ready (debug_in_ready),
        .trace_data     (trace_data),
        .trace_src      (trace_src),
        .trace_overflow (trace_overflow),
        .trace_lost     (trace_lost),
        .trace_valid    (trace_valid),
        .trace_ready    (trace_ready),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [127:0] actual,
                               input logic [127:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Drives one flit (called on a falling edge) and returns on the falling
    // edge after the rising edge that accepted it.
    task automatic sendFlit(input logic last, input logic [15:0] data);
        int waitCycles = 0;
        debug_in.valid = 1'b1;
        debug_in.last  = last;
        debug_in.data  = data;
        while (!debug_in_ready && waitCycles < 200) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!debug_in_ready) begin
            checkOutput("flit_accept_timeout", debug_in_ready, 1'b1);
        end
        @(negedge clk);
        debug_in.valid = 1'b0;
    endtask

    // Sends the packet in pktQ, marking the final flit as last. It then checks
    // whether an event became visible one cycle after that flit.
    task automatic applyStimulus(input logic expectValid);
        for (int i = 0; i < pktQ.size(); i++) begin
            sendFlit(i == pktQ.size() - 1, pktQ[i]);
        end
        checkOutput("valid_after_last", trace_valid, expectValid);
    endtask

    task automatic buildEvent(input logic [15:0] dest, input logic [15:0] src,
                              input logic [15:0] flags, input int n,
                              input logic [15:0] seed);
        pktQ.delete();
        pktQ.push_back(dest);
        pktQ.push_back(src);
        pktQ.push_back(flags);
        for (int i = 0; i < n; i++) begin
            pktQ.push_back(seed + 16'h1111 * 16'(i + 1));
        end
    endtask

    task automatic sendEvent(input logic [15:0] src, input logic [15:0] seed);
        event_t                  ev;
        logic [NUM_WORDS*16-1:0] flat;
        buildEvent(OWN_ID, src, 16'h8000, NUM_WORDS, seed);
        for (int i = 0; i < NUM_WORDS; i++) begin
            flat[i*16 +: 16] = pktQ[3 + i];
        end
        ev.data = flat[WIDTH-1:0];
        ev.src  = src;
        ev.ovf  = modelOvf;
        ev.lost = modelLost;
        sb.push_back(ev);
        modelOvf  = 1'b0;
        modelLost = 16'h0000;
        applyStimulus(1'b1);
    endtask

    task automatic sendOverflow(input logic [15:0] count);
        logic [16:0] sum;
        pktQ.delete();
        pktQ.push_back(OWN_ID);
        pktQ.push_back(16'h0002);
        pktQ.push_back(16'h9400);
        pktQ.push_back(count);
        sum       = {1'b0, modelLost} + {1'b0, count};
        modelLost = sum[16] ? 16'hFFFF : sum[15:0];
        modelOvf  = 1'b1;
        applyStimulus(1'b0);
    endtask

    task automatic sendDropped(input string tag);
        if (modelDrop != 16'hFFFF) modelDrop = modelDrop + 16'd1;
        applyStimulus(1'b0);
        checkOutput(tag, drop_count, modelDrop);
    endtask

    // Changes trace_ready just after a rising edge, then realigns to the
    // falling edge.
    task automatic setReady(input logic value);
        @(posedge clk);
        #1 trace_ready = value;
        @(negedge clk);
    endtask

    // Monitor: pops and compares each event on its handshake. It also checks
    // that held outputs stay put and that the input stalls while an event is
    // held.
    event_t expEv;
    event_t prevEv;
    logic   prevHeld = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prevHeld = 1'b0;
        end else begin
            if (trace_valid) begin
                checkOutput("in_ready_while_held", debug_in_ready, 1'b0);
                if (prevHeld) begin
                    checkOutput("stable_data", trace_data, prevEv.data);
                    checkOutput("stable_src", trace_src, prevEv.src);
                    checkOutput("stable_ovf", trace_overflow, prevEv.ovf);
                    checkOutput("stable_lost", trace_lost, prevEv.lost);
                end
                if (trace_ready) begin
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_event", trace_valid, 1'b0);
                    end else begin
                        expEv = sb.pop_front();
                        checkOutput("trace_data", trace_data, expEv.data);
                        checkOutput("trace_src", trace_src, expEv.src);
                        checkOutput("trace_overflow", trace_overflow, expEv.ovf);
                        checkOutput("trace_lost", trace_lost, expEv.lost);
                    end
                end
            end
            prevHeld    = trace_valid && !trace_ready;
            prevEv.data = trace_data;
            prevEv.src  = trace_src;
            prevEv.ovf  = trace_overflow;
            prevEv.lost = trace_lost;
        end
    end

    // Watchdog so that a stuck DUT still ends the run.
    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, scoreboard holds %0d", sb.size());
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst         = 1'b1;
        id          = OWN_ID;
        debug_in    = '0;
        trace_ready = 1'b1;
        modelOvf    = 1'b0;
        modelLost   = 16'h0000;
        modelDrop   = 16'h0000;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        // Reset values.
        checkOutput("rst_trace_valid", trace_valid, 1'b0);
        checkOutput("rst_trace_data", trace_data, '0);
        checkOutput("rst_trace_src", trace_src, 16'h0000);
        checkOutput("rst_trace_overflow", trace_overflow, 1'b0);
        checkOutput("rst_trace_lost", trace_lost, 16'h0000);
        checkOutput("rst_drop_count", drop_count, 16'h0000);
        checkOutput("rst_in_ready", debug_in_ready, 1'b1);

        // Single event: words 0x1111..0x7777 from SRC 0001.
        sendEvent(16'h0001, 16'h0000);

        // Backpressure: the first event is held for ten cycles while a second
        // packet waits on the input.
        setReady(1'b0);
        sendEvent(16'h00A1, 16'h0100);
        fork
            begin
                sendEvent(16'h00B2, 16'h0200);
            end
            begin
                repeat (10) begin
                    @(negedge clk);
                    checkOutput("bp_in_ready_low", debug_in_ready, 1'b0);
                end
                setReady(1'b1);
            end
        join

        // Overflow accumulation is attached to the next event only.
        sendOverflow(16'd3);
        sendOverflow(16'd4);
        sendEvent(16'h0011, 16'h0300);
        sendEvent(16'h0012, 16'h0400);

        // Misrouted, short, long, wrong-type and header-truncated packets.
        buildEvent(16'h0006, 16'h0001, 16'h8000, NUM_WORDS, 16'h0000);
        sendDropped("drop_misrouted");
        buildEvent(OWN_ID, 16'h0001, 16'h8000, 5, 16'h0000);
        sendDropped("drop_short");
        buildEvent(OWN_ID, 16'h0001, 16'h8000, 9, 16'h0000);
        sendDropped("drop_long");
        buildEvent(OWN_ID, 16'h0001, 16'h4000, NUM_WORDS, 16'h0000);
        sendDropped("drop_bad_type");
        pktQ.delete();
        pktQ.push_back(OWN_ID);
        pktQ.push_back(16'h0001);
        sendDropped("drop_truncated_hdr");
        sendEvent(16'h0021, 16'h0500);

        // Lost count saturates instead of wrapping.
        repeat (3) sendOverflow(16'hFFFF);
        sendEvent(16'h0031, 16'h0600);

        // Reset in the middle of a payload discards the partial event and the
        // pending overflow.
        sendOverflow(16'd9);
        sendFlit(1'b0, OWN_ID);
        sendFlit(1'b0, 16'h0041);
        sendFlit(1'b0, 16'h8000);
        repeat (3) sendFlit(1'b0, 16'hAAAA);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        modelOvf  = 1'b0;
        modelLost = 16'h0000;
        modelDrop = 16'h0000;
        checkOutput("midrst_drop_count", drop_count, modelDrop);
        checkOutput("midrst_trace_valid", trace_valid, 1'b0);
        checkOutput("midrst_in_ready", debug_in_ready, 1'b1);
        sendEvent(16'h0042, 16'h0700);

        // drop_count saturation: single-flit truncated packets back to back.
        debug_in.valid = 1'b1;
        debug_in.last  = 1'b1;
        debug_in.data  = 16'h0000;
        repeat (65540) @(negedge clk);
        debug_in.valid = 1'b0;
        modelDrop = 16'hFFFF;
        checkOutput("drop_count_sat", drop_count, modelDrop);
        checkOutput("drop_sat_trace_valid", trace_valid, 1'b0);
        sendEvent(16'h0051, 16'h0800);
        checkOutput("drop_count_sat_hold", drop_count, modelDrop);

        repeat (2) @(negedge clk);
        checkOutput("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
